// File: rtl/play_control.sv
`default_nettype none
// ============================================================================
// Module   : play_control
// Purpose  : Lane-change sequencer for the player sprite: erase, reload, redraw.
// Revision : 1.0
// ============================================================================
module play_control #(
    parameter int PW = 16,
    parameter int PH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       move_left,
    input  logic       move_right,
    output logic       ld_1,
    output logic       ld_2,
    output logic       ld_3,
    output logic       ld_4,
    output logic       erase,
    output logic       draw,
    output logic       plot,
    output logic [4:0] x_off,
    output logic [3:0] y_off,
    output logic [1:0] lane,
    output logic       busy
);

    typedef enum logic [2:0] {
        INIT_LOAD = 3'd0,
        INIT_DRAW = 3'd1,
        IDLE      = 3'd2,
        ERASE_SET = 3'd3,
        ERASE_PIX = 3'd4,
        LOAD      = 3'd5,
        DRAW_PIX  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        P_NONE  = 2'd0,
        P_LEFT  = 2'd1,
        P_RIGHT = 2'd2
    } pend_t;

    localparam logic [4:0] X_LAST = 5'(PW - 1);
    localparam logic [3:0] Y_LAST = 4'(PH - 1);

    state_t     state, state_n;
    pend_t      pending, pending_n;
    logic [1:0] target, target_n;
    logic       prev_left, prev_right;
    logic       rise_l, rise_r;
    logic       last_pix, scan, take, accept, ld_en, target_ok;
    logic [1:0] ld_sel;

    assign rise_l   = move_left  & ~prev_left;
    assign rise_r   = move_right & ~prev_right;
    assign last_pix = (x_off == X_LAST) && (y_off == Y_LAST);

    always_comb begin
        target_n  = (pending == P_LEFT) ? lane - 2'd1 : lane + 2'd1;
        target_ok = (pending == P_LEFT) ? (lane != 2'd0) : (lane != 2'd3);
    end

    always_comb begin
        state_n = state;
        busy    = 1'b1;
        plot    = 1'b0;
        erase   = 1'b0;
        draw    = 1'b0;
        ld_en   = 1'b0;
        ld_sel  = lane;
        scan    = 1'b0;
        take    = 1'b0;
        accept  = 1'b0;
        case (state)
            INIT_LOAD: begin
                draw    = 1'b1;
                ld_en   = 1'b1;
                state_n = INIT_DRAW;
            end
            INIT_DRAW, DRAW_PIX: begin
                plot = 1'b1;
                scan = 1'b1;
                if (last_pix) state_n = IDLE;
            end
            IDLE: begin
                busy = 1'b0;
                if (pending != P_NONE) begin
                    take = 1'b1;
                    // Out-of-range requests are simply dropped.
                    if (target_ok) begin
                        accept  = 1'b1;
                        state_n = ERASE_SET;
                    end
                end
            end
            ERASE_SET: begin
                erase   = 1'b1;
                state_n = ERASE_PIX;
            end
            ERASE_PIX: begin
                plot = 1'b1;
                scan = 1'b1;
                if (last_pix) state_n = LOAD;
            end
            LOAD: begin
                draw    = 1'b1;
                ld_en   = 1'b1;
                ld_sel  = target;
                state_n = DRAW_PIX;
            end
            default: state_n = INIT_LOAD;
        endcase
        // While reset is held the outputs show the reset values.
        if (reset) begin
            busy   = 1'b1;
            plot   = 1'b0;
            erase  = 1'b0;
            draw   = 1'b0;
            ld_en  = 1'b1;
            ld_sel = 2'd0;
        end
    end

    always_comb begin
        pending_n = take ? P_NONE : pending;
        if (rise_l ^ rise_r) pending_n = rise_l ? P_LEFT : P_RIGHT;
    end

    assign ld_1 = ld_en && (ld_sel == 2'd0);
    assign ld_2 = ld_en && (ld_sel == 2'd1);
    assign ld_3 = ld_en && (ld_sel == 2'd2);
    assign ld_4 = ld_en && (ld_sel == 2'd3);

    always_ff @(posedge clock) begin
        prev_left  <= move_left;
        prev_right <= move_right;
        if (reset) begin
            state   <= INIT_LOAD;
            pending <= P_NONE;
            lane    <= 2'd0;
            target  <= 2'd0;
            x_off   <= 5'd0;
            y_off   <= 4'd0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            if (accept) target <= target_n;
            if (state == LOAD) lane <= target;
            if (scan) begin
                if (x_off == X_LAST) begin
                    x_off <= 5'd0;
                    y_off <= (y_off == Y_LAST) ? 4'd0 : y_off + 4'd1;
                end else begin
                    x_off <= x_off + 5'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_play_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_play_control
// Purpose  : Scoreboard bench for play_control (PW=16, PH=8).
// Revision : 1.0
// ============================================================================
module tb_play_control;

    localparam int PW = 16;
    localparam int PH = 8;

    typedef logic [18:0] snap_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       ld_1, ld_2, ld_3, ld_4, erase, draw, plot, busy;
    logic [4:0] x_off;
    logic [3:0] y_off;
    logic [1:0] lane;

    snap_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";

    always #5 clock = ~clock;

    play_control #(.PW(PW), .PH(PH)) dut (
        .clock(clock), .reset(reset),
        .move_left(move_left), .move_right(move_right),
        .ld_1(ld_1), .ld_2(ld_2), .ld_3(ld_3), .ld_4(ld_4),
        .erase(erase), .draw(draw), .plot(plot),
        .x_off(x_off), .y_off(y_off), .lane(lane), .busy(busy)
    );

    // Snapshot layout: busy, ld_4..ld_1, erase, draw, plot, x_off, y_off, lane
    function automatic snap_t mk(input logic b, input logic [3:0] ld, input logic er,
                                 input logic dr, input logic pl, input int x,
                                 input int y, input int ln);
        return {b, ld, er, dr, pl, 5'(x), 4'(y), 2'(ln)};
    endfunction

    function automatic snap_t dut_snap();
        return {busy, ld_4, ld_3, ld_2, ld_1, erase, draw, plot, x_off, y_off, lane};
    endfunction

    task automatic check_eq(input string tag, input snap_t obs, input snap_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b_%b_%b%b%b_x%0d_y%0d_l%0d required %b_%b_%b%b%b_x%0d_y%0d_l%0d",
                     tag, obs[18], obs[17:14], obs[13], obs[12], obs[11], obs[10:6], obs[5:2], obs[1:0],
                     exp[18], exp[17:14], exp[13], exp[12], exp[11], exp[10:6], exp[5:2], exp[1:0]);
        end
    endtask

    task automatic push_idle(input int n, input int ln);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, ln));
    endtask

    task automatic push_scan(input int ln);
        for (int y = 0; y < PH; y++)
            for (int x = 0; x < PW; x++)
                exp_q.push_back(mk(1, 4'b0000, 0, 0, 1, x, y, ln));
    endtask

    task automatic push_init();
        exp_q.push_back(mk(1, 4'b0001, 0, 1, 0, 0, 0, 0));
        push_scan(0);
    endtask

    task automatic push_move(input int from, input int to, input int n_idle);
        push_idle(n_idle, from);
        exp_q.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 0, from));
        push_scan(from);
        exp_q.push_back(mk(1, 4'(1 << to), 0, 1, 0, 0, 0, from));
        push_scan(to);
    endtask

    // Sample at the falling edge; inputs change 1 ns after the rising edge.
    task automatic cyc();
        @(negedge clock);
        if (exp_q.size() > 0) check_eq(phase, dut_snap(), exp_q.pop_front());
        @(posedge clock);
        #1;
    endtask

    task automatic run_out();
        while (exp_q.size() > 0) cyc();
    endtask

    task automatic do_move(input logic right, input int from, input int to);
        push_move(from, to, 2);
        if (right) move_right = 1'b1; else move_left = 1'b1;
        cyc();
        move_right = 1'b0;
        move_left  = 1'b0;
        run_out();
        push_idle(3, to);
        run_out();
    endtask

    task automatic no_move(input logic l, input logic r, input int ln);
        push_idle(6, ln);
        move_left  = l;
        move_right = r;
        repeat (3) cyc();
        move_left  = 1'b0;
        move_right = 1'b0;
        run_out();
        push_idle(4, ln);
        run_out();
    endtask

    initial begin
        @(posedge clock);
        #1;
        exp_q.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 0, 0));
        cyc();
        reset = 1'b0;
        phase = "init_draw";
        push_init();
        push_idle(3, 0);
        run_out();

        phase = "left_at_lane0";
        no_move(1'b1, 1'b0, 0);
        phase = "simultaneous";
        no_move(1'b1, 1'b1, 0);

        phase = "right_0_1";
        do_move(1'b1, 0, 1);
        phase = "left_1_0";
        do_move(1'b0, 1, 0);

        // Requests arriving mid-move: RIGHT during erase, then LEFT during draw.
        phase = "queued_req";
        push_move(0, 1, 2);
        push_move(1, 0, 1);
        push_idle(20, 0);
        move_right = 1'b1;
        for (int i = 1; exp_q.size() > 0; i++) begin
            cyc();
            case (i)
                1:   move_right = 1'b0;
                10:  move_right = 1'b1;
                12:  move_right = 1'b0;
                200: move_left  = 1'b1;
                202: move_left  = 1'b0;
                default: ;
            endcase
        end

        phase = "right_0_1b";
        do_move(1'b1, 0, 1);
        phase = "right_1_2";
        do_move(1'b1, 1, 2);
        phase = "right_2_3";
        do_move(1'b1, 2, 3);
        phase = "right_at_lane3";
        no_move(1'b0, 1'b1, 3);

        // Reset while redrawing at pixel (5,3) of the lane-2 sprite.
        phase = "pre_reset_move";
        push_move(3, 2, 2);
        move_left = 1'b1;
        cyc();
        move_left = 1'b0;
        while (exp_q.size() > 75) cyc();
        exp_q.delete();
        reset = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        phase = "reset_mid_draw";
        push_init();
        push_idle(3, 0);
        run_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached in phase %s", phase);
        $fatal(1);
    end

endmodule
`default_nettype wire
